control_unit: RTL and testbench

Multi-cycle control FSM that sits directly upstream of `Data_path` and drives every one of its control inputs. It fetches a 32-bit instruction over the shared data bus into an internal instruction register (IR). It decodes the IR and sequences the datapath through execute, memory and write-back cycles. It handles the bus handshake with memory and stops permanently on HALT.

---
 rtl/control_unit.sv | 185 ++++++++++++++++++
 tb/tb_control_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: multi-cycle control FSM for Data_path.
// Fetches an instruction into IR over the shared bus, decodes it, and
// sequences execute / memory / write-back cycles. HALT is terminal until reset.
module control_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned AWIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instr_in,
  input  logic             mem_ready,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [5:0]       opcode,
  output logic [4:0]       oppA,
  output logic [4:0]       oppB,
  output logic [WIDTH-1:0] literal,
  output logic             regEn,
  output logic             increment,
  output logic             Branch_En,
  output logic             fetch,
  output logic             DataBus_En,
  output logic             store_en,
  output logic             wrData,
  output logic             wrAdd,
  output logic             store_PC,
  output logic             literalEn,
  output logic             PCEn,
  output logic             Valid,
  output logic             halted
);

  // Field positions below assume a 32-bit instruction word.
  if (WIDTH != 32) begin : g_bad_width
    $error("control_unit: WIDTH must be 32");
  end
  if (AWIDTH < 1) begin : g_bad_awidth
    $error("control_unit: AWIDTH must be at least 1");
  end

  localparam logic [5:0] OP_LOAD   = 6'b100000;
  localparam logic [5:0] OP_STORE  = 6'b100001;
  localparam logic [5:0] OP_JUMP   = 6'b110000;
  localparam logic [5:0] OP_HALT   = 6'b111111;
  localparam logic [5:0] ALU_ADDL  = 6'b010000;
  localparam logic [5:0] ALU_PASSB = 6'b001111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_W,
    S_DECODE,
    S_EXEC,
    S_ADDR,
    S_LD_W,
    S_ST_D,
    S_ST_W,
    S_WB,
    S_JUMP,
    S_JLD,
    S_HALT
  } state_t;

  state_t           state, next;
  logic [WIDTH-1:0] ir;
  logic [5:0]       ir_op;
  logic [1:0]       ir_class;
  logic             is_load, is_store, is_jump, is_halt;

  assign ir_op    = ir[31:26];
  assign ir_class = ir[31:30];
  assign is_load  = (ir_op == OP_LOAD);
  assign is_store = (ir_op == OP_STORE);
  assign is_jump  = (ir_op == OP_JUMP);
  assign is_halt  = (ir_op == OP_HALT);

  // Operand fields come straight from IR, so they hold until the next fetch completes.
  assign oppA    = ir[25:21];
  assign oppB    = ir[20:16];
  assign literal = {{(WIDTH-16){ir[15]}}, ir[15:0]};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next;
  end

  // Instruction register: loaded only on the edge that completes the fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              ir <= '0;
    else if (state == S_FETCH_W && mem_ready) ir <= instr_in;
  end

  // Next-state and datapath control decode.
  always_comb begin
    next       = state;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    opcode     = ir_op;
    regEn      = 1'b0;
    increment  = 1'b0;
    Branch_En  = 1'b0;
    fetch      = 1'b0;
    DataBus_En = 1'b0;
    store_en   = 1'b0;
    wrData     = 1'b0;
    wrAdd      = 1'b0;
    store_PC   = 1'b0;
    literalEn  = 1'b0;
    PCEn       = 1'b0;
    Valid      = (state != S_IDLE) && (state != S_HALT);
    halted     = 1'b0;
    unique case (state)
      S_IDLE: next = S_FETCH_A;
      S_FETCH_A: begin
        fetch = 1'b1;
        wrAdd = 1'b1;
        next  = S_FETCH_W;
      end
      S_FETCH_W: begin
        mem_rd = 1'b1;
        if (mem_ready) next = S_DECODE;
      end
      S_DECODE: begin
        increment = 1'b1;
        PCEn      = 1'b1;
        if (ir_class == 2'b00 || ir_class == 2'b01) next = S_EXEC;
        else if (is_load || is_store)               next = S_ADDR;
        else if (is_jump)                           next = S_JUMP;
        else if (is_halt)                           next = S_HALT;
        else                                        next = S_FETCH_A;
      end
      S_EXEC: begin
        wrData    = 1'b1;
        literalEn = (ir_class == 2'b01);
        next      = S_WB;
      end
      S_ADDR: begin
        opcode    = ALU_ADDL;
        literalEn = 1'b1;
        wrAdd     = 1'b1;
        next      = is_load ? S_LD_W : S_ST_D;
      end
      S_LD_W: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          store_en = 1'b1;
          wrData   = 1'b1;
          next     = S_WB;
        end
      end
      S_ST_D: begin
        opcode = ALU_PASSB;
        wrData = 1'b1;
        next   = S_ST_W;
      end
      S_ST_W: begin
        mem_wr     = 1'b1;
        DataBus_En = 1'b1;
        if (mem_ready) next = S_FETCH_A;
      end
      S_WB: begin
        regEn = 1'b1;
        next  = S_FETCH_A;
      end
      S_JUMP: begin
        Branch_En = 1'b1;
        literalEn = 1'b1;
        opcode    = ALU_ADDL;
        wrData    = 1'b1;
        next      = S_JLD;
      end
      S_JLD: begin
        PCEn = 1'b1;
        next = S_FETCH_A;
      end
      S_HALT: begin
        halted = 1'b1;
        next   = S_HALT;
      end
      default: next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed table, hand-written corner sequences and random
// instruction streams, each compared cycle by cycle against a transaction-level
// model that expands an instruction into its expected cycle trace.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_in = '0;
  logic        mem_ready = 1'b0;
  logic        mem_rd, mem_wr;
  logic [5:0]  opcode;
  logic [4:0]  oppA, oppB;
  logic [31:0] literal;
  logic        regEn, increment, Branch_En, fetch, DataBus_En, store_en;
  logic        wrData, wrAdd, store_PC, literalEn, PCEn, Valid, halted;

  control_unit #(.WIDTH(32), .AWIDTH(32)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .opcode(opcode), .oppA(oppA), .oppB(oppB),
    .literal(literal), .regEn(regEn), .increment(increment), .Branch_En(Branch_En),
    .fetch(fetch), .DataBus_En(DataBus_En), .store_en(store_en), .wrData(wrData),
    .wrAdd(wrAdd), .store_PC(store_PC), .literalEn(literalEn), .PCEn(PCEn),
    .Valid(Valid), .halted(halted)
  );

  always #5 clk = ~clk;

  // Control-bit masks for the packed 15-bit control view below.
  localparam logic [14:0] RD  = 15'h4000, WR  = 15'h2000, REG = 15'h1000, INC = 15'h0800;
  localparam logic [14:0] BR  = 15'h0400, FET = 15'h0200, DBE = 15'h0100, STE = 15'h0080;
  localparam logic [14:0] WRD = 15'h0040, WRA = 15'h0020, SPC = 15'h0010, LIT = 15'h0008;
  localparam logic [14:0] PCE = 15'h0004, VAL = 15'h0002, HLT = 15'h0001;

  logic [14:0] ctl;
  assign ctl = {mem_rd, mem_wr, regEn, increment, Branch_En, fetch, DataBus_En,
                store_en, wrData, wrAdd, store_PC, literalEn, PCEn, Valid, halted};

  typedef struct {
    logic [14:0] ctl;
    logic [5:0]  op;
    logic [31:0] ir;
    logic        ready;
    logic [31:0] data;
    logic        dec;
  } cyc_t;

  typedef struct {
    logic [31:0] instr;
    int          fw;
    int          mw;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] lit;
  } vec_t;

  cyc_t        q[$];
  logic [31:0] ir_m = '0;
  int          compared = 0;
  int          mismatched = 0;
  logic [4:0]  dec_a, dec_b;
  logic [31:0] dec_lit;
  int          reg_idx, reg_cnt, rd_after_dec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [14:0] c, input logic [5:0] op, input logic rdy,
                      input logic [31:0] d, input logic dec);
    cyc_t r;
    r.ctl = c; r.op = op; r.ir = ir_m; r.ready = rdy; r.data = d; r.dec = dec;
    q.push_back(r);
  endtask

  // Expand one instruction into its expected per-cycle trace. Non-wait cycles
  // carry random stray mem_ready and bus garbage that must be ignored.
  task automatic model_instr(input logic [31:0] instr, input int fw, input int mw);
    logic [5:0] old_op, op;
    old_op = ir_m[31:26];
    op     = instr[31:26];
    push(FET | WRA | VAL, old_op, rb(), $urandom, 1'b0);
    for (int k = 0; k < fw; k++) push(RD | VAL, old_op, 1'b0, $urandom, 1'b0);
    push(RD | VAL, old_op, 1'b1, instr, 1'b0);
    ir_m = instr;
    push(INC | PCE | VAL, op, rb(), $urandom, 1'b1);
    if (op[5] == 1'b0) begin
      push(WRD | VAL | (op[4] ? LIT : 15'h0), op, rb(), $urandom, 1'b0);
      push(REG | VAL, op, rb(), $urandom, 1'b0);
    end else if (op == 6'b100000) begin
      push(LIT | WRA | VAL, 6'b010000, rb(), $urandom, 1'b0);
      for (int k = 0; k < mw; k++) push(RD | VAL, op, 1'b0, $urandom, 1'b0);
      push(RD | STE | WRD | VAL, op, 1'b1, $urandom, 1'b0);
      push(REG | VAL, op, rb(), $urandom, 1'b0);
    end else if (op == 6'b100001) begin
      push(LIT | WRA | VAL, 6'b010000, rb(), $urandom, 1'b0);
      push(WRD | VAL, 6'b001111, rb(), $urandom, 1'b0);
      for (int k = 0; k < mw; k++) push(WR | DBE | VAL, op, 1'b0, $urandom, 1'b0);
      push(WR | DBE | VAL, op, 1'b1, $urandom, 1'b0);
    end else if (op == 6'b110000) begin
      push(BR | LIT | WRD | VAL, 6'b010000, rb(), $urandom, 1'b0);
      push(PCE | VAL, op, rb(), $urandom, 1'b0);
    end else if (op == 6'b111111) begin
      for (int k = 0; k < 21; k++) push(HLT, op, rb(), $urandom, 1'b0);
    end
  endtask

  // Apply queued cycles (all when limit < 0) and compare every output.
  task automatic play(input int limit);
    int idx = 0;
    int dec_idx = 1000000;
    reg_idx = -1; reg_cnt = 0; rd_after_dec = 0;
    while (q.size() > 0 && (limit < 0 || idx < limit)) begin
      cyc_t r;
      r = q.pop_front();
      @(posedge clk); #1;
      mem_ready = r.ready;
      instr_in  = r.data;
      #1;
      check("ctl", 64'(ctl), 64'(r.ctl));
      check("opcode", 64'(opcode), 64'(r.op));
      check("fields", {16'h0, oppA, oppB, literal},
            {16'h0, r.ir[25:21], r.ir[20:16], {16{r.ir[15]}}, r.ir[15:0]});
      if (r.dec) begin
        dec_idx = idx; dec_a = oppA; dec_b = oppB; dec_lit = literal;
      end
      if (regEn) begin
        reg_cnt++;
        if (reg_idx < 0) reg_idx = idx;
      end
      if (mem_rd && idx > dec_idx) rd_after_dec++;
      idx++;
    end
  endtask

  task automatic do_reset();
    #3 reset = 1'b0;
    #1;
    check("reset_ctl", 64'(ctl), 64'h0);
    check("reset_fields", {10'h0, opcode, oppA, oppB, literal}, 64'h0);
    q.delete();
    ir_m = '0;
    mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("idle_ctl", 64'(ctl), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    tbl[0] = '{32'h00221000, 0, 0, 5'd1, 5'd2, 32'h00001000};
    tbl[1] = '{32'h80A0FFFC, 0, 3, 5'd5, 5'd0, 32'hFFFFFFFC};
    tbl[2] = '{32'h84220004, 1, 2, 5'd1, 5'd2, 32'h00000004};
    tbl[3] = '{32'h44430005, 2, 0, 5'd2, 5'd3, 32'h00000005};
    tbl[4] = '{32'hA8000000, 0, 0, 5'd0, 5'd0, 32'h00000000};
    tbl[5] = '{32'hC0000010, 3, 0, 5'd0, 5'd0, 32'h00000010};
    tbl[6] = '{32'h3C858001, 0, 1, 5'd4, 5'd5, 32'hFFFF8001};

    // Reset from power-up, then abandon a LOAD in its first LD_W wait cycle.
    do_reset();
    model_instr(32'h80A0FFFC, 0, 3);
    play(5);
    check("ldw_rd_before_reset", 64'(mem_rd), 64'h1);
    do_reset();

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      model_instr(tbl[i].instr, tbl[i].fw, tbl[i].mw);
      play(-1);
      check("tbl_oppA", 64'(dec_a), 64'(tbl[i].a));
      check("tbl_oppB", 64'(dec_b), 64'(tbl[i].b));
      check("tbl_literal", 64'(dec_lit), 64'(tbl[i].lit));
    end

    // R-type: regEn only in cycle 5.
    model_instr(32'h00221000, 0, 0);
    play(-1);
    check("rtype_regen_cycle", 64'(reg_idx), 64'd4);
    check("rtype_regen_count", 64'(reg_cnt), 64'd1);

    // LOAD with 3 waits: mem_rd held four cycles in LD_W.
    model_instr(32'h80A0FFFC, 0, 3);
    play(-1);
    check("load_rd_cycles", 64'(rd_after_dec), 64'd4);
    check("load_regen_cycle", 64'(reg_idx), 64'd8);

    // NOP: no write-back.
    model_instr(32'hA8000000, 0, 0);
    play(-1);
    check("nop_no_regen", 64'(reg_cnt), 64'd0);

    // JUMP then HALT; halted holds for 20 further cycles.
    model_instr(32'hC0000010, 0, 0);
    play(-1);
    model_instr(32'hFC000000, 0, 0);
    play(-1);
    check("halt_sticky", 64'(halted), 64'h1);
    do_reset();

    // Random instruction stream.
    for (int n = 0; n < 80; n++) begin
      logic [31:0] ins;
      logic [5:0]  op;
      int          sel;
      ins = $urandom;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2: op = {2'b00, 4'($urandom)};
        3, 4:    op = {2'b01, 4'($urandom)};
        5, 9:    op = 6'b100000;
        6:       op = 6'b100001;
        7:       op = 6'b110000;
        default: begin
          op = {1'b1, 5'($urandom)};
          while (op == 6'b100000 || op == 6'b100001 || op == 6'b110000 || op == 6'b111111)
            op = {1'b1, 5'($urandom)};
        end
      endcase
      ins[31:26] = op;
      model_instr(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      play(-1);
    end
    model_instr(32'hFC000000 | ($urandom & 32'h03FFFFFF), 0, 0);
    play(-1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
